// File: rtl/axi4_lite_pkg.sv
// Shared types and defaults for the reduced AXI4-lite initiator family.
// Provides the FSM state encoding and a timeout counter width helper.
package axi4_lite_pkg;

  localparam int unsigned ADDR_W_DEF  = 32'd32;
  localparam int unsigned DATA_W_DEF  = 32'd32;
  localparam int unsigned TIMEOUT_DEF = 32'd256;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  // Counter width able to hold LIMIT-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    if (limit <= 32'd2) begin
      w = 32'd1;
    end else begin
      w = $clog2(limit);
    end
    return w;
  endfunction

endpackage

// File: rtl/axi4_lite_timeout.sv
// Loadable up-counter with clear and enable; expire is registered and is high
// while the count sits at LIMIT-1. LIMIT of 0 disables expiry.
module axi4_lite_timeout
  import axi4_lite_pkg::*;
#(
  parameter int unsigned LIMIT = TIMEOUT_DEF,
  parameter int unsigned CNT_W = cnt_width(LIMIT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [CNT_W-1:0] ld_val,
  input  logic             en,
  output logic             expire
);

  localparam logic             ENABLED  = (LIMIT != 32'd0);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LIMIT - 32'd1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(32'd1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic             expire_r;

  // Next count: clear beats load beats increment.
  always_comb begin
    count_nx_s = count_r;
    if (clr) begin
      count_nx_s = {CNT_W{1'b0}};
    end else if (ld) begin
      count_nx_s = ld_val;
    end else if (en) begin
      count_nx_s = count_r + ONE;
    end else begin
      count_nx_s = count_r;
    end
  end

  // Count register and registered terminal-count flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r  <= {CNT_W{1'b0}};
      expire_r <= 1'b0;
    end else begin
      count_r  <= count_nx_s;
      expire_r <= ENABLED && (count_nx_s == LAST_CNT);
    end
  end

  assign expire = expire_r;

endmodule

// File: rtl/axi4_lite_master.sv
// Single-outstanding AXI4-lite initiator: command/response front end mapped
// onto AW/W/B and AR/R, with a per-transaction timeout abort.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                awvalid,
  output logic [ADDR_W-1:0]   awaddr,
  input  logic                awready,
  output logic                wvalid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready,
  output logic                arvalid,
  output logic [ADDR_W-1:0]   araddr,
  input  logic                arready,
  input  logic                rvalid,
  input  logic [DATA_W-1:0]   rdata,
  output logic                rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);

  state_t              state_r, state_nx_s;
  logic                cmd_ready_r, cmd_ready_nx_s;
  logic                awvalid_r, awvalid_nx_s;
  logic                wvalid_r, wvalid_nx_s;
  logic                bready_r, bready_nx_s;
  logic                arvalid_r, arvalid_nx_s;
  logic                rready_r, rready_nx_s;
  logic                rsp_valid_r, rsp_valid_nx_s;
  logic                rsp_err_r, rsp_err_nx_s;
  logic [DATA_W-1:0]   rsp_rdata_r, rsp_rdata_nx_s;
  logic [ADDR_W-1:0]   awaddr_r, awaddr_nx_s;
  logic [ADDR_W-1:0]   araddr_r, araddr_nx_s;
  logic [DATA_W-1:0]   wdata_r, wdata_nx_s;
  logic [STRB_W-1:0]   wstrb_r, wstrb_nx_s;
  logic                aw_done_r, aw_done_nx_s;
  logic                w_done_r, w_done_nx_s;
  logic                accept_s, abort_s, busy_s, expire_s;
  logic                aw_hs_s, w_hs_s;

  assign busy_s = (state_r == ST_WR) || (state_r == ST_WR_RESP) ||
                  (state_r == ST_RD_ADDR) || (state_r == ST_RD_DATA);

  axi4_lite_timeout #(
    .LIMIT (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept_s),
    .ld     (1'b0),
    .ld_val ({CNT_W{1'b0}}),
    .en     (busy_s),
    .expire (expire_s)
  );

  // Next-state and next-output logic; handshakes take priority over expiry.
  always_comb begin
    state_nx_s     = state_r;
    cmd_ready_nx_s = cmd_ready_r;
    awvalid_nx_s   = awvalid_r;
    wvalid_nx_s    = wvalid_r;
    bready_nx_s    = bready_r;
    arvalid_nx_s   = arvalid_r;
    rready_nx_s    = rready_r;
    rsp_valid_nx_s = rsp_valid_r;
    rsp_err_nx_s   = rsp_err_r;
    rsp_rdata_nx_s = rsp_rdata_r;
    awaddr_nx_s    = awaddr_r;
    araddr_nx_s    = araddr_r;
    wdata_nx_s     = wdata_r;
    wstrb_nx_s     = wstrb_r;
    aw_done_nx_s   = aw_done_r;
    w_done_nx_s    = w_done_r;
    accept_s       = 1'b0;
    abort_s        = 1'b0;
    aw_hs_s        = awvalid_r && awready;
    w_hs_s         = wvalid_r && wready;

    case (state_r)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          accept_s     = 1'b1;
          rsp_err_nx_s = 1'b0;
          if (cmd_we) begin
            state_nx_s   = ST_WR;
            awaddr_nx_s  = cmd_addr;
            wdata_nx_s   = cmd_wdata;
            wstrb_nx_s   = cmd_wstrb;
            awvalid_nx_s = 1'b1;
            wvalid_nx_s  = 1'b1;
            aw_done_nx_s = 1'b0;
            w_done_nx_s  = 1'b0;
          end else begin
            state_nx_s   = ST_RD_ADDR;
            araddr_nx_s  = cmd_addr;
            arvalid_nx_s = 1'b1;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WR: begin
        aw_done_nx_s = aw_done_r || aw_hs_s;
        w_done_nx_s  = w_done_r || w_hs_s;
        if (aw_hs_s) begin
          awvalid_nx_s = 1'b0;
        end else begin
          awvalid_nx_s = awvalid_r;
        end
        if (w_hs_s) begin
          wvalid_nx_s = 1'b0;
        end else begin
          wvalid_nx_s = wvalid_r;
        end
        if (aw_done_nx_s && w_done_nx_s) begin
          state_nx_s  = ST_WR_RESP;
          bready_nx_s = 1'b1;
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_WR;
        end
      end
      ST_WR_RESP: begin
        if (bvalid && bready_r) begin
          state_nx_s     = ST_RSP;
          bready_nx_s    = 1'b0;
          rsp_valid_nx_s = 1'b1;
          rsp_err_nx_s   = 1'b0;
          rsp_rdata_nx_s = {DATA_W{1'b0}};
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_WR_RESP;
        end
      end
      ST_RD_ADDR: begin
        if (arvalid_r && arready) begin
          state_nx_s   = ST_RD_DATA;
          arvalid_nx_s = 1'b0;
          rready_nx_s  = 1'b1;
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (rvalid && rready_r) begin
          state_nx_s     = ST_RSP;
          rready_nx_s    = 1'b0;
          rsp_valid_nx_s = 1'b1;
          rsp_err_nx_s   = 1'b0;
          rsp_rdata_nx_s = rdata;
        end else if (expire_s) begin
          abort_s = 1'b1;
        end else begin
          state_nx_s = ST_RD_DATA;
        end
      end
      ST_RSP: begin
        if (rsp_ready) begin
          state_nx_s     = ST_IDLE;
          rsp_valid_nx_s = 1'b0;
        end else begin
          state_nx_s = ST_RSP;
        end
      end
      default: begin
        state_nx_s     = ST_IDLE;
        awvalid_nx_s   = 1'b0;
        wvalid_nx_s    = 1'b0;
        bready_nx_s    = 1'b0;
        arvalid_nx_s   = 1'b0;
        rready_nx_s    = 1'b0;
        rsp_valid_nx_s = 1'b0;
      end
    endcase

    // An abort drops every valid/ready and reports an error with zero data.
    if (abort_s) begin
      state_nx_s     = ST_RSP;
      cmd_ready_nx_s = 1'b0;
      awvalid_nx_s   = 1'b0;
      wvalid_nx_s    = 1'b0;
      bready_nx_s    = 1'b0;
      arvalid_nx_s   = 1'b0;
      rready_nx_s    = 1'b0;
      rsp_valid_nx_s = 1'b1;
      rsp_err_nx_s   = 1'b1;
      rsp_rdata_nx_s = {DATA_W{1'b0}};
    end else begin
      cmd_ready_nx_s = (state_nx_s == ST_IDLE);
    end
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      awaddr_r    <= {ADDR_W{1'b0}};
      araddr_r    <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      wstrb_r     <= {STRB_W{1'b0}};
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cmd_ready_r <= cmd_ready_nx_s;
      awvalid_r   <= awvalid_nx_s;
      wvalid_r    <= wvalid_nx_s;
      bready_r    <= bready_nx_s;
      arvalid_r   <= arvalid_nx_s;
      rready_r    <= rready_nx_s;
      rsp_valid_r <= rsp_valid_nx_s;
      rsp_err_r   <= rsp_err_nx_s;
      rsp_rdata_r <= rsp_rdata_nx_s;
      awaddr_r    <= awaddr_nx_s;
      araddr_r    <= araddr_nx_s;
      wdata_r     <= wdata_nx_s;
      wstrb_r     <= wstrb_nx_s;
      aw_done_r   <= aw_done_nx_s;
      w_done_r    <= w_done_nx_s;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign awvalid   = awvalid_r;
  assign wvalid    = wvalid_r;
  assign bready    = bready_r;
  assign arvalid   = arvalid_r;
  assign rready    = rready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;
  assign awaddr    = awaddr_r;
  assign araddr    = araddr_r;
  assign wdata     = wdata_r;
  assign wstrb     = wstrb_r;

endmodule

// File: tb/tb_axi4_lite_master.sv
// Directed bench for axi4_lite_master against a small RAM slave model whose
// ready and response each lag by one cycle; AR can be stalled for the abort case.
module tb_axi4_lite_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        arvalid, arready, rvalid, rready;
  logic        stall_ar;

  int n_cmp = 0;
  int n_mis = 0;
  int ar_hs = 0;
  int b_hs  = 0;

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  // RAM slave: word i resets to {A5A5, i}; writes land at the live awaddr.
  logic [31:0] mem [16];
  logic        b_pend, r_pend;
  logic [3:0]  r_idx;

  always @(posedge clk) begin
    if (rst) begin
      awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; b_pend <= 1'b0;
      arready <= 1'b0; rvalid <= 1'b0; rdata <= 32'h0; r_pend <= 1'b0; r_idx <= 4'h0;
      for (int i = 0; i < 16; i++) mem[i] <= {16'hA5A5, 16'(i)};
    end else begin
      awready <= awvalid && !awready;
      wready  <= wvalid && !wready;
      arready <= arvalid && !arready && !stall_ar;
      if (b_pend) begin bvalid <= 1'b1; b_pend <= 1'b0; end
      if (wvalid && wready) begin
        for (int b = 0; b < 4; b++)
          if (wstrb[b]) mem[awaddr[5:2]][8*b +: 8] <= wdata[8*b +: 8];
        b_pend <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (r_pend) begin rvalid <= 1'b1; rdata <= mem[r_idx]; r_pend <= 1'b0; end
      if (arvalid && arready) begin r_pend <= 1'b1; r_idx <= araddr[5:2]; end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && arvalid && arready) ar_hs <= ar_hs + 1;
    if (!rst && bvalid && bready)   b_hs  <= b_hs + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where rsp_valid is first seen.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb, output logic [31:0] rd, output logic err,
                         output int lat, output int arv_cyc, output logic aw_held);
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = strb;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; arv_cyc = 0; aw_held = 1'b1;
    if (arvalid) arv_cyc++;
    if (we && awaddr !== addr) aw_held = 1'b0;
    while (!rsp_valid && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (arvalid) arv_cyc++;
      if (we && !rsp_valid && awaddr !== addr) aw_held = 1'b0;
    end
    rd = rsp_rdata; err = rsp_err;
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq({tag, "_rspv_drop"}, {31'h0, rsp_valid}, 32'h0);
    check_eq({tag, "_cmdrdy_up"}, {31'h0, cmd_ready}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        err, held, ok;
  int          lat, arv, ar0, b0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_ar = 1'b0;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valids", {25'h0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_err}, 32'h0);
    check_eq("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    check_eq("rst_awaddr", awaddr, 32'h0);
    check_eq("rst_araddr", araddr, 32'h0);
    check_eq("rst_wdata", wdata, 32'h0);
    check_eq("rst_wstrb", {28'h0, wstrb}, 32'h0);
    check_eq("rst_rdata", rsp_rdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    ar0 = ar_hs;
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, arv, held);
    check_eq("rd10_data", rd, 32'hA5A5_0004);
    check_eq("rd10_err", {31'h0, err}, 32'h0);
    check_eq("rd10_lat", lat, 32'd4);
    check_eq("rd10_ar_hs", ar_hs - ar0, 32'd1);
    check_eq("rd10_araddr", araddr, 32'h10);
    finish_rsp("rd10");

    b0 = b_hs;
    run_cmd(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, rd, err, lat, arv, held);
    check_eq("wr20_lat", lat, 32'd4);
    check_eq("wr20_rdata0", rd, 32'h0);
    check_eq("wr20_err", {31'h0, err}, 32'h0);
    check_eq("wr20_b_hs", b_hs - b0, 32'd1);
    check_eq("wr20_aw_held", {31'h0, held}, 32'h1);
    finish_rsp("wr20");
    run_cmd(1'b0, 32'h20, 32'h0, 4'h0, rd, err, lat, arv, held);
    check_eq("rd20_data", rd, 32'hDEAD_BEEF);
    finish_rsp("rd20");

    run_cmd(1'b1, 32'h24, 32'h1122_3344, 4'h3, rd, err, lat, arv, held);
    finish_rsp("wr24");
    run_cmd(1'b0, 32'h24, 32'h0, 4'h0, rd, err, lat, arv, held);
    check_eq("rd24_data", rd, 32'hA5A5_3344);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_rdata !== 32'hA5A5_3344) ok = 1'b0;
    end
    check_eq("stall_stable", {31'h0, ok}, 32'h1);
    finish_rsp("stall");
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, arv, held);
    check_eq("b2b_lat", lat, 32'd4);
    check_eq("b2b_data", rd, 32'hA5A5_0004);
    finish_rsp("b2b");

    stall_ar = 1'b1;
    run_cmd(1'b0, 32'h10, 32'h0, 4'h0, rd, err, lat, arv, held);
    check_eq("to_arvalid_cycles", arv, 32'd16);
    check_eq("to_lat", lat, 32'd16);
    check_eq("to_err", {31'h0, err}, 32'h1);
    check_eq("to_rdata", rd, 32'h0);
    check_eq("to_arvalid_drop", {31'h0, arvalid}, 32'h0);
    stall_ar = 1'b0;
    finish_rsp("to");

    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h28; cmd_wdata = 32'h5555_AAAA; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_eq("rstw_in_wr_resp", {31'h0, bready}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstw_valids", {26'h0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'h0);
    check_eq("rstw_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    ok = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    check_eq("rstw_no_rsp", {31'h0, ok}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
